// File: rtl/ecc_double_and_add_if.sv
// Operand/result bundle for the ECC scalar multiplier.
// The master side supplies curve, point and scalar; the slave returns kP and done.
interface ecc_double_and_add_if #(
  parameter int n = 193
);
  logic [n-1:0] p;
  logic [n-1:0] c;
  logic [n-1:0] x1;
  logic [n-1:0] y1;
  logic [n-1:0] a;
  logic [n-1:0] x3;
  logic [n-1:0] y3;
  logic         done;

  modport master (output p, c, x1, y1, a, input x3, y3, done);
  modport slave  (input p, c, x1, y1, a, output x3, y3, done);
endinterface

// File: rtl/ecc_double_and_add.sv
// Elliptic-curve scalar multiplier kP over GF(p), affine coordinates,
// left-to-right double-and-add. One shared field multiplier and one shared
// inverter are sequenced by the main FSM through a start/busy handshake.
module ecc_double_and_add #(
  parameter int n = 193
) (
  input  logic                 clk,
  input  logic                 reset,
  ecc_double_and_add_if.slave  bus
);
  localparam int iw = $clog2(n);

  typedef logic [n-1:0] fe_t;
  typedef enum logic [2:0] {
    st_idle, st_load, st_dbl, st_chk_bit, st_add_pt, st_next_bit, st_fin, st_done
  } state_t;

  // Operands are below p < 2^(n-1), so sums never overflow n bits.
  function automatic fe_t fadd(fe_t u, fe_t v, fe_t m);
    fe_t s;
    s = u + v;
    return (s >= m) ? s - m : s;
  endfunction

  function automatic fe_t fsub(fe_t u, fe_t v, fe_t m);
    return (u >= v) ? u - v : u - v + m;
  endfunction

  // u/2 mod m for odd m: add m first when u is odd so the shift is exact.
  function automatic fe_t fhalf(fe_t u, fe_t m);
    fe_t s;
    s = u[0] ? u + m : u;
    return s >> 1;
  endfunction

  state_t          state;
  logic [2:0]      step;
  logic [iw-1:0]   idx;
  logic            from_add;
  fe_t             p_r, c_r, px, py, a_r;
  fe_t             qx, qy, t0, t1, lam;
  logic            qinf;

  logic            mul_start, mul_busy;
  fe_t             mul_a, mul_b, mul_r;
  logic [iw-1:0]   mul_cnt;

  logic            inv_start, inv_busy;
  fe_t             inv_a, iu, iv, ix1, ix2, inv_r;

  logic            unit_busy;
  fe_t             x_new;

  assign unit_busy = mul_start | mul_busy | inv_start | inv_busy;

  // New x after lam^2 is in mul_r: doubling subtracts qx twice, addition qx and px.
  always_comb begin
    x_new = fsub(fsub(mul_r, qx, p_r), (state == st_dbl) ? qx : px, p_r);
  end

  // Shared multiplier: one interleaved shift-add step per cycle, multiplier MSB first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_busy <= 1'b0;
      mul_cnt  <= '0;
      mul_r    <= '0;
    end else if (mul_start) begin
      mul_busy <= 1'b1;
      mul_cnt  <= iw'(n - 1);
      mul_r    <= '0;
    end else if (mul_busy) begin
      // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
      mul_r   <= mul_b[mul_cnt] ? fadd(fadd(mul_r, mul_r, p_r), mul_a, p_r)
                                : fadd(mul_r, mul_r, p_r);
      mul_cnt <= mul_cnt - iw'(1);
      if (mul_cnt == '0) mul_busy <= 1'b0;
    end
  end

  // Shared inverter: binary extended Euclid, invariants ix1*inv_a = iu, ix2*inv_a = iv (mod p).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inv_busy <= 1'b0;
      iu       <= '0;
      iv       <= '0;
      ix1      <= '0;
      ix2      <= '0;
      inv_r    <= '0;
    end else if (inv_start) begin
      inv_busy <= 1'b1;
      iu       <= inv_a;
      iv       <= p_r;
      ix1      <= fe_t'(1);
      ix2      <= '0;
    end else if (inv_busy) begin
      if (iu == fe_t'(1)) begin
        inv_r    <= ix1;
        inv_busy <= 1'b0;
      end else if (iv == fe_t'(1)) begin
        inv_r    <= ix2;
        inv_busy <= 1'b0;
      end else if (!iu[0]) begin
        iu  <= iu >> 1;
        ix1 <= fhalf(ix1, p_r);
      end else if (!iv[0]) begin
        iv  <= iv >> 1;
        ix2 <= fhalf(ix2, p_r);
      end else if (iu >= iv) begin
        iu  <= iu - iv;
        ix1 <= fsub(ix1, ix2, p_r);
      end else begin
        iv  <= iv - iu;
        ix2 <= fsub(ix2, ix1, p_r);
      end
    end
  end

  // Main sequencer: scalar bit loop, point double/add micro-steps, result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: every datapath register is cleared so an aborted run leaves nothing behind.
      state     <= st_idle;
      step      <= '0;
      idx       <= '0;
      from_add  <= 1'b0;
      p_r       <= '0;
      c_r       <= '0;
      px        <= '0;
      py        <= '0;
      a_r       <= '0;
      qx        <= '0;
      qy        <= '0;
      qinf      <= 1'b1;
      t0        <= '0;
      t1        <= '0;
      lam       <= '0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      inv_start <= 1'b0;
      inv_a     <= '0;
      bus.x3    <= '0;
      bus.y3    <= '0;
      bus.done  <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      inv_start <= 1'b0;
      case (state)
        st_idle: begin
          p_r   <= bus.p;
          c_r   <= bus.c;
          px    <= bus.x1;
          py    <= bus.y1;
          a_r   <= bus.a;
          state <= st_load;
        end
        st_load: begin
          idx   <= iw'(n - 1);
          qinf  <= 1'b1;
          qx    <= '0;
          qy    <= '0;
          step  <= '0;
          state <= st_dbl;
        end
        st_dbl: if (!unit_busy) begin
          case (step)
            3'd0: if (qinf || qy == '0) begin
              qinf     <= 1'b1;
              from_add <= 1'b0;
              state    <= from_add ? st_next_bit : st_chk_bit;
            end else begin
              mul_a <= qx; mul_b <= qx; mul_start <= 1'b1; step <= 3'd1;
            end
            3'd1: begin
              t0    <= fadd(fadd(mul_r, mul_r, p_r), fadd(mul_r, a_r, p_r), p_r);
              inv_a <= fadd(qy, qy, p_r); inv_start <= 1'b1; step <= 3'd2;
            end
            3'd2: begin mul_a <= t0; mul_b <= inv_r; mul_start <= 1'b1; step <= 3'd3; end
            3'd3: begin
              lam <= mul_r; mul_a <= mul_r; mul_b <= mul_r; mul_start <= 1'b1; step <= 3'd4;
            end
            3'd4: begin
              t1 <= x_new; mul_a <= lam; mul_b <= fsub(qx, x_new, p_r);
              mul_start <= 1'b1; step <= 3'd5;
            end
            default: begin
              qx       <= t1;
              qy       <= fsub(mul_r, qy, p_r);
              step     <= '0;
              from_add <= 1'b0;
              state    <= from_add ? st_next_bit : st_chk_bit;
            end
          endcase
        end
        st_chk_bit: state <= c_r[idx] ? st_add_pt : st_next_bit;
        st_add_pt: if (!unit_busy) begin
          case (step)
            3'd0: if (qinf) begin
              qx <= px; qy <= py; qinf <= 1'b0; state <= st_next_bit;
            end else if (qx == px) begin
              if (qy == py) begin
                from_add <= 1'b1;
                state    <= st_dbl;
              end else begin
                qinf  <= 1'b1;
                state <= st_next_bit;
              end
            end else begin
              inv_a <= fsub(px, qx, p_r); inv_start <= 1'b1; step <= 3'd1;
            end
            3'd1: begin
              mul_a <= fsub(py, qy, p_r); mul_b <= inv_r; mul_start <= 1'b1; step <= 3'd2;
            end
            3'd2: begin
              lam <= mul_r; mul_a <= mul_r; mul_b <= mul_r; mul_start <= 1'b1; step <= 3'd3;
            end
            3'd3: begin
              t1 <= x_new; mul_a <= lam; mul_b <= fsub(qx, x_new, p_r);
              mul_start <= 1'b1; step <= 3'd4;
            end
            default: begin
              qx    <= t1;
              qy    <= fsub(mul_r, qy, p_r);
              step  <= '0;
              state <= st_next_bit;
            end
          endcase
        end
        st_next_bit: begin
          if (idx == '0) begin
            state <= st_fin;
          end else begin
            idx   <= idx - iw'(1);
            state <= st_dbl;
          end
        end
        st_fin: begin
          bus.x3   <= qinf ? '0 : qx;
          bus.y3   <= qinf ? '0 : qy;
          bus.done <= 1'b1;
          state    <= st_done;
        end
        st_done: state <= st_done;
        default: state <= st_idle;
      endcase
    end
  end
endmodule

// File: tb/tb_ecc_double_and_add.sv
// Bench for ecc_double_and_add: fixed P-192 and p=17 vectors on the full-width
// instance, randomized small-field runs on a narrow instance checked each cycle
// against a plain-arithmetic point model.
module tb_ecc_double_and_add;
  localparam int nb = 193;
  localparam int ns = 12;
  localparam int big_limit   = 20000;
  localparam int small_limit = 64 * ns * ns;

  typedef logic [255:0]  w_t;
  typedef logic [nb-1:0] big_t;
  typedef struct { bit inf; longint x; longint y; } pt_t;

  localparam big_t P192 = 193'hfffffffffffffffffffffffffffffffeffffffffffffffff;
  localparam big_t A192 = 193'hfffffffffffffffffffffffffffffffefffffffffffffffc;
  localparam big_t GX   = 193'h188da80eb03090f67cbf20eb43a18800f4ff0afd82ff1012;
  localparam big_t GY   = 193'h07192b95ffc8da78631011ed6b24cdd573f977a11e794811;
  localparam big_t G2X  = 193'hdafebf5828783f2ad35534631588a3f629a70fb16982a888;
  localparam big_t G2Y  = 193'hdd6bda0d993da0fa46b27bbc141b868f59331afa5c7e93ab;

  logic clk = 1'b0;
  logic rst_b;
  logic rst_s;
  always #5 clk = ~clk;

  ecc_double_and_add_if #(.n(nb)) bus_b ();
  ecc_double_and_add_if #(.n(ns)) bus_s ();

  ecc_double_and_add #(.n(nb)) dut   (.clk(clk), .reset(rst_b), .bus(bus_b));
  ecc_double_and_add #(.n(ns)) dut_s (.clk(clk), .reset(rst_s), .bus(bus_s));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input w_t act, input w_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural curve model (small fields) ----------------
  function automatic longint md(input longint v, input longint m);
    longint r;
    r = v % m;
    if (r < 0) r += m;
    return r;
  endfunction

  // Fermat inverse u^(m-2) mod m; m is prime.
  function automatic longint minv(input longint u, input longint m);
    longint r, b, e;
    r = 1; b = md(u, m); e = m - 2;
    while (e > 0) begin
      if (e % 2 == 1) r = (r * b) % m;
      b = (b * b) % m;
      e = e / 2;
    end
    return r;
  endfunction

  function automatic pt_t pdbl(input pt_t q, input longint a, input longint m);
    pt_t r;
    longint lam;
    r.inf = 1'b1; r.x = 0; r.y = 0;
    if (q.inf || q.y == 0) return r;
    lam = md(md(3 * q.x * q.x + a, m) * minv(2 * q.y, m), m);
    r.inf = 1'b0;
    r.x = md(lam * lam - 2 * q.x, m);
    r.y = md(lam * (q.x - r.x) - q.y, m);
    return r;
  endfunction

  function automatic pt_t padd(input pt_t q, input pt_t b, input longint a, input longint m);
    pt_t r;
    longint lam;
    r.inf = 1'b1; r.x = 0; r.y = 0;
    if (q.inf) return b;
    if (q.x == b.x) return (q.y == b.y) ? pdbl(q, a, m) : r;
    lam = md(md(b.y - q.y, m) * minv(b.x - q.x, m), m);
    r.inf = 1'b0;
    r.x = md(lam * lam - q.x - b.x, m);
    r.y = md(lam * (q.x - r.x) - q.y, m);
    return r;
  endfunction

  function automatic pt_t smul(input longint k, input pt_t b, input longint a,
                               input longint m, input int bits);
    pt_t q;
    q.inf = 1'b1; q.x = 0; q.y = 0;
    for (int i = bits - 1; i >= 0; i--) begin
      q = pdbl(q, a, m);
      if (((k >> i) & 1) == 1) q = padd(q, b, a, m);
    end
    return q;
  endfunction

  function automatic big_t rnd_big();
    big_t v;
    for (int k = 0; k < nb; k++) v[k] = 1'($urandom);
    return v;
  endfunction

  // ---------------- full-width instance ----------------
  task automatic run_big(input string name, input big_t pp, input big_t cc, input big_t xx,
                         input big_t yy, input big_t aa, input big_t ex, input big_t ey);
    int cyc;
    rst_b = 1'b1;
    bus_b.p = pp; bus_b.c = cc; bus_b.x1 = xx; bus_b.y1 = yy; bus_b.a = aa;
    repeat (2) @(posedge clk);
    #1;
    check({name, "_rst_x3"}, w_t'(bus_b.x3), '0);
    check({name, "_rst_y3"}, w_t'(bus_b.y3), '0);
    check({name, "_rst_done"}, w_t'(bus_b.done), '0);
    rst_b = 1'b0;
    cyc = 0;
    while (!bus_b.done && cyc < big_limit) begin
      @(posedge clk); #1; cyc++;
    end
    check({name, "_done"}, w_t'(bus_b.done), w_t'(1));
    check({name, "_x3"}, w_t'(bus_b.x3), w_t'(ex));
    check({name, "_y3"}, w_t'(bus_b.y3), w_t'(ey));
  endtask

  // ---------------- narrow instance, randomized ----------------
  logic [ns-1:0] exp_sx, exp_sy;
  bit            mon_en = 1'b0;

  // Outputs stay at reset values until done, then must equal the model's kP.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_s.done) begin
        check("s_x3", w_t'(bus_s.x3), w_t'(exp_sx));
        check("s_y3", w_t'(bus_s.y3), w_t'(exp_sy));
      end else begin
        check("s_pre_done_out", w_t'({bus_s.x3, bus_s.y3}), '0);
      end
    end
  end

  longint primes[7] = '{17, 23, 97, 251, 509, 1021, 2039};

  task automatic run_small(input int run);
    longint m, aa, xx, yy, kk;
    pt_t    base, r;
    int     cyc;
    m  = primes[$urandom_range(0, 6)];
    aa = longint'($urandom) % m;
    xx = longint'($urandom) % m;
    yy = longint'($urandom) % m;
    kk = longint'($urandom) % (longint'(1) << ns);
    if (run == 0) kk = 0;
    if (run == 1) yy = 0;
    base.inf = 1'b0; base.x = xx; base.y = yy;
    r = smul(kk, base, aa, m, ns);
    exp_sx = r.inf ? '0 : ns'(r.x);
    exp_sy = r.inf ? '0 : ns'(r.y);
    rst_s = 1'b1;
    bus_s.p = ns'(m); bus_s.a = ns'(aa); bus_s.x1 = ns'(xx); bus_s.y1 = ns'(yy); bus_s.c = ns'(kk);
    repeat (2) @(posedge clk);
    #1;
    rst_s  = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    // Operands were latched on that edge; later input changes must not matter.
    bus_s.p = ns'($urandom); bus_s.a = ns'($urandom); bus_s.c = ns'($urandom);
    bus_s.x1 = ns'($urandom); bus_s.y1 = ns'($urandom);
    cyc = 0;
    while (!bus_s.done && cyc < small_limit) begin
      @(posedge clk); #1; cyc++;
    end
    check("s_done", w_t'(bus_s.done), w_t'(1));
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    @(negedge clk);
    #2 rst_s = 1'b1;
    #1 check("s_async_rst", w_t'({bus_s.done, bus_s.x3, bus_s.y3}), '0);
  endtask

  initial begin
    pt_t g17, r;
    rst_b = 1'b1;
    rst_s = 1'b1;
    bus_s.p = '0; bus_s.c = '0; bus_s.x1 = '0; bus_s.y1 = '0; bus_s.a = '0;

    // Pin the model with hand-worked p=17, a=2, P=(5,1) multiples.
    g17.inf = 1'b0; g17.x = 5; g17.y = 1;
    r = smul(2, g17, 2, 17, 8);
    check("model_2p", w_t'({r.inf, 16'(r.x), 16'(r.y)}), w_t'({1'b0, 16'd6, 16'd3}));
    r = smul(5, g17, 2, 17, 8);
    check("model_5p", w_t'({r.inf, 16'(r.x), 16'(r.y)}), w_t'({1'b0, 16'd9, 16'd16}));
    r = smul(19, g17, 2, 17, 8);
    check("model_19p_inf", w_t'(r.inf), w_t'(1));

    // P-192 vectors.
    run_big("p192_c2", P192, big_t'(2), GX, GY, A192, G2X, G2Y);
    @(negedge clk);
    #2 rst_b = 1'b1;
    #1;
    check("p192_async_rst_after_done", w_t'({bus_b.done, bus_b.x3}), '0);
    check("p192_async_rst_after_done_y", w_t'(bus_b.y3), '0);
    #1 rst_b = 1'b0;
    repeat (400) @(posedge clk);
    #1 check("p192_midrun_not_done", w_t'(bus_b.done), '0);
    @(negedge clk);
    #2 rst_b = 1'b1;
    #1 check("p192_midrun_rst", w_t'({bus_b.done, bus_b.x3}), '0);
    run_big("p192_c2_after_abort", P192, big_t'(2), GX, GY, A192, G2X, G2Y);
    run_big("p192_c0", P192, big_t'(0), GX, GY, A192, '0, '0);
    run_big("p192_c1", P192, big_t'(1), GX, GY, A192, GX, GY);

    // Held result while inputs churn.
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      bus_b.c = rnd_big(); bus_b.x1 = rnd_big(); bus_b.y1 = rnd_big();
      @(negedge clk);
      check("hold_x3", w_t'({bus_b.done, bus_b.x3}), w_t'({1'b1, GX}));
      check("hold_y3", w_t'(bus_b.y3), w_t'(GY));
    end

    // Small curve on the full-width instance.
    run_big("p17_c2",  big_t'(17), big_t'(2),  big_t'(5), big_t'(1), big_t'(2), big_t'(6),  big_t'(3));
    run_big("p17_c3",  big_t'(17), big_t'(3),  big_t'(5), big_t'(1), big_t'(2), big_t'(10), big_t'(6));
    run_big("p17_c5",  big_t'(17), big_t'(5),  big_t'(5), big_t'(1), big_t'(2), big_t'(9),  big_t'(16));
    run_big("p17_c19", big_t'(17), big_t'(19), big_t'(5), big_t'(1), big_t'(2), '0,         '0);
    run_big("p17_c20", big_t'(17), big_t'(20), big_t'(5), big_t'(1), big_t'(2), big_t'(5),  big_t'(1));

    // Randomized narrow-field runs.
    for (int run = 0; run < 14; run++) run_small(run);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
